// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the handshaked data memory: access sizes, FSM states
// and the size-to-byte-count helper.
package mem_if_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the core and the data memory.
interface data_mem_responder_if;
    // Both channels use the same rule: a beat transfers on a rising edge where
    // valid && ready; the sender keeps valid and payload stable until then.
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/data_mem_responder_load_extend.sv
// Sign- or zero-extends right-aligned load bytes to 64 bits according to the access size.
module load_extend
    import mem_if_pkg::*;
(
    input  logic [63:0] raw,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [63:0] value
);

    logic fill;

    always_comb begin
        fill  = 1'b0;
        value = raw;
        case (size)
            SZ_B: begin
                fill  = ~is_unsigned & raw[7];
                value = {{56{fill}}, raw[7:0]};
            end
            SZ_H: begin
                fill  = ~is_unsigned & raw[15];
                value = {{48{fill}}, raw[15:0]};
            end
            SZ_W: begin
                fill  = ~is_unsigned & raw[31];
                value = {{32{fill}}, raw[31:0]};
            end
            default: value = raw;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle byte-addressed data memory serving sized little-endian loads and
// stores with configurable wait states and an error response.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_BYTES = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   bus,
    output state_t                dbg_state
);

    localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        lat_write, lat_unsigned;
    logic [63:0] lat_addr, lat_wdata;
    logic [1:0]  lat_size;

    logic [63:0] rdata_q;
    logic        error_q;
    logic [7:0]  mem [DEPTH_BYTES];

    logic        accept, enter_resp, leave_resp;
    logic        acc_write, acc_unsigned, acc_error;
    logic [63:0] acc_addr, acc_wdata;
    logic [1:0]  acc_size;
    logic [3:0]  acc_bytes;
    logic [AW-1:0] base;
    logic [63:0] raw, ext;

    assign accept     = bus.req_valid && (state_q == IDLE);
    assign leave_resp = (state_q == RESP) && bus.resp_ready;
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    // With zero wait states the access happens on the accept edge itself, so the
    // live request fields are used until they have been latched.
    assign acc_write    = (state_q == IDLE) ? bus.req_write    : lat_write;
    assign acc_addr     = (state_q == IDLE) ? bus.req_addr     : lat_addr;
    assign acc_wdata    = (state_q == IDLE) ? bus.req_wdata    : lat_wdata;
    assign acc_size     = (state_q == IDLE) ? bus.req_size     : lat_size;
    assign acc_unsigned = (state_q == IDLE) ? bus.req_unsigned : lat_unsigned;

    assign acc_bytes = size_bytes(acc_size);
    assign acc_error = ((acc_addr[2:0] & 3'(acc_bytes - 4'd1)) != 3'd0)
                    || (acc_addr >= 64'(DEPTH_BYTES));
    assign base      = acc_addr[AW-1:0];

    always_comb begin
        raw = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < acc_bytes) raw[8*i +: 8] = mem[base + AW'(i)];
        end
    end

    load_extend u_load_extend (
        .raw         (raw),
        .size        (acc_size),
        .is_unsigned (acc_unsigned),
        .value       (ext)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_write    <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_size     <= SZ_B;
            lat_unsigned <= 1'b0;
        end else if (accept) begin
            lat_write    <= bus.req_write;
            lat_addr     <= bus.req_addr;
            lat_wdata    <= bus.req_wdata;
            lat_size     <= bus.req_size;
            lat_unsigned <= bus.req_unsigned;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            error_q <= 1'b0;
        end else if (enter_resp) begin
            error_q <= acc_error;
            rdata_q <= (acc_error || acc_write) ? 64'd0 : ext;
        end else if (leave_resp) begin
            rdata_q <= '0;
            error_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'd0;
        end else if (enter_resp && acc_write && !acc_error) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < acc_bytes) mem[base + AW'(i)] <= acc_wdata[8*i +: 8];
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_error = error_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;
    import mem_if_pkg::*;

    localparam int DEPTH = 64;
    localparam int WAITC = 2;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;
    int     n_tests = 0;
    int     n_fail  = 0;

    logic [63:0] exp_q[$];
    logic        err_q[$];
    logic [7:0]  model_mem [DEPTH];
    logic [63:0] last_rdata;

    data_mem_responder_if bus ();

    data_mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour: error rule, little-endian byte array, extension by arithmetic.
    task automatic model_access(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [1:0] size, input logic uns,
                                output logic [63:0] data, output logic err);
        int n;
        n    = 1 << size;
        err  = ((addr % 64'(n)) != 0) || (addr >= 64'(DEPTH));
        data = '0;
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < n; i++) model_mem[int'(addr) + i] = 8'((wdata >> (8 * i)) & 64'hFF);
            end else begin
                for (int i = 0; i < n; i++) data = data | (64'(model_mem[int'(addr) + i]) << (8 * i));
                if (!uns && n < 8 && ((data >> (8 * n - 1)) & 64'd1) == 64'd1)
                    data = data | (~64'd0 << (8 * n));
            end
        end
    endtask

    task automatic drive_idle();
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.req_size     = SZ_B;
        bus.req_unsigned = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic wr, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [1:0] size, input logic uns,
                          input int hold);
        logic [63:0] e_data, first_data;
        logic        e_err, first_err;
        int          lat;
        model_access(wr, addr, wdata, size, uns, e_data, e_err);
        exp_q.push_back(e_data);
        err_q.push_back(e_err);
        @(negedge clk);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.resp_ready   = (hold == 0);
        @(posedge clk);
        #1;
        // Scribble on the request fields; they must be ignored once accepted.
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'($urandom_range(0, 1));
        bus.req_addr     = {$urandom, $urandom};
        bus.req_wdata    = {$urandom, $urandom};
        bus.req_size     = 2'($urandom_range(0, 3));
        bus.req_unsigned = 1'($urandom_range(0, 1));
        lat = 1;
        while (!bus.resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency_edges"}, 64'(lat), 64'(WAITC + 1));
        first_data = bus.resp_rdata;
        first_err  = bus.resp_error;
        last_rdata = first_data;
        check({tag, "_rdata"}, first_data, exp_q.pop_front());
        check({tag, "_error"}, 64'(first_err), 64'(err_q.pop_front()));
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 64'(bus.resp_valid), 64'd1);
            check({tag, "_hold_rdata"}, bus.resp_rdata, first_data);
            check({tag, "_hold_error"}, 64'(bus.resp_error), 64'(first_err));
            check({tag, "_hold_req_ready"}, 64'(bus.req_ready), 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_done_valid"}, 64'(bus.resp_valid), 64'd0);
        check({tag, "_done_req_ready"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        logic        wr, uns;
        logic [1:0]  sz;
        logic [63:0] addr;
        int          n;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'd0;
        drive_idle();
        bus.resp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_rdata", bus.resp_rdata, 64'd0);
        check("rst_resp_error", 64'(bus.resp_error), 64'd0);
        rst_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_req_ready", 64'(bus.req_ready), 64'd1);
            check("idle_resp_valid", 64'(bus.resp_valid), 64'd0);
        end

        do_req("st_d8", 1'b1, 64'd8, 64'h8877665544332211, SZ_D, 1'b0, 0);
        do_req("ld_d8", 1'b0, 64'd8, 64'd0, SZ_D, 1'b0, 0);
        check("ld_d8_value", last_rdata, 64'h8877665544332211);
        do_req("ld_b15", 1'b0, 64'd15, 64'd0, SZ_B, 1'b0, 0);
        check("ld_b15_value", last_rdata, 64'hFFFFFFFFFFFFFF88);
        do_req("ld_h10", 1'b0, 64'd10, 64'd0, SZ_H, 1'b1, 0);
        check("ld_h10_value", last_rdata, 64'h4433);

        do_req("st_b9", 1'b1, 64'd9, 64'hAB, SZ_B, 1'b0, 0);
        do_req("ld_d8b", 1'b0, 64'd8, 64'd0, SZ_D, 1'b0, 0);
        check("ld_d8b_value", last_rdata, 64'h887766554433AB11);

        do_req("ld_w2_misaligned", 1'b0, 64'd2, 64'd0, SZ_W, 1'b0, 0);
        do_req("st_d64_range", 1'b1, 64'd64, 64'hDEADBEEFCAFEF00D, SZ_D, 1'b0, 0);
        do_req("ld_d56", 1'b0, 64'd56, 64'd0, SZ_D, 1'b0, 0);
        check("ld_d56_value", last_rdata, 64'd0);

        do_req("bp_ld_d8", 1'b0, 64'd8, 64'd0, SZ_D, 1'b0, 5);

        // Reset while a byte store to address 0 is waiting.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 64'd0;
        bus.req_wdata = 64'hFF;
        bus.req_size  = SZ_B;
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rstwait_resp_valid", 64'(bus.resp_valid), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rstwait_req_ready_after", 64'(bus.req_ready), 64'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rstwait_no_resp", 64'(bus.resp_valid), 64'd0);
        end
        do_req("rstwait_ld_b0", 1'b0, 64'd0, 64'd0, SZ_B, 1'b1, 0);
        check("rstwait_ld_b0_value", last_rdata, 64'd0);
        do_req("rstwait_ld_d8", 1'b0, 64'd8, 64'd0, SZ_D, 1'b0, 0);

        for (int t = 0; t < 80; t++) begin
            wr   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            n    = 1 << sz;
            addr = 64'($urandom_range(0, DEPTH + 7));
            if ($urandom_range(0, 3) != 0) addr = addr & ~64'(n - 1);
            do_req("rand", wr, addr, {$urandom, $urandom}, sz, uns, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
